// File: rtl/decoder3to8_seq_pkg.sv
`default_nettype none
// ---- decoder3to8_seq_pkg : shared FSM encoding, counter width, one-hot helper (rev 1.0) ----
package decoder3to8_seq_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [7:0] onehot3(input logic [2:0] code);
        logic [7:0] one;
        one = 8'd1;
        return one << code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder3to8_seq_code_fifo.sv
`default_nettype none
// ---- decoder3to8_seq_code_fifo : synchronous code buffer with flush (rev 1.0) ----
module decoder3to8_seq_code_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // A push is refused when full even if a pop frees a slot this same cycle.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder3to8_seq.sv
`default_nettype none
// ---- decoder3to8_seq : buffers 3-bit codes and replays them as timed one-hot pulses (rev 1.0) ----
module decoder3to8_seq
    import decoder3to8_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic In0,
    input  logic In1,
    input  logic In2,
    input  logic InValid,
    output logic InReady,
    input  logic Flush,
    output logic Out0,
    output logic Out1,
    output logic Out2,
    output logic Out3,
    output logic Out4,
    output logic Out5,
    output logic Out6,
    output logic Out7,
    output logic OutValid,
    output logic Busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       out_q, out_d;
    logic             ready_en_q;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [2:0]       fifo_head;

    // Holds InReady low while in reset and until the first edge after release.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    assign InReady = ready_en_q && !fifo_full;

    decoder3to8_seq_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_code_fifo (
        .clk   (Clk),
        .rst_n (Rst_n),
        .flush (Flush),
        .push  (InValid && InReady),
        .din   ({In2, In1, In0}),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        fifo_pop = 1'b0;
        if (Flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        out_d    = onehot3(fifo_head);
                        cnt_d    = HOLD_LOAD;
                        state_d  = DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        out_d = '0;
                        if (GAP_CYCLES > 0) begin
                            cnt_d   = GAP_LOAD;
                            state_d = GAP;
                        end else if (!fifo_empty) begin
                            // Back-to-back replay without an all-zero cycle.
                            fifo_pop = 1'b1;
                            out_d    = onehot3(fifo_head);
                            cnt_d    = HOLD_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        out_d    = onehot3(fifo_head);
                        cnt_d    = HOLD_LOAD;
                        state_d  = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    out_d   = '0;
                end
            endcase
        end
    end

    assign {Out7, Out6, Out5, Out4, Out3, Out2, Out1, Out0} = out_q;
    assign OutValid = |out_q;
    assign Busy     = (state_q != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_decoder3to8_seq.sv
`default_nettype none
// ---- tb_decoder3to8_seq : directed self-checking bench for decoder3to8_seq (rev 1.0) ----
module tb_decoder3to8_seq;

    logic       Clk;
    logic       Rst_n;
    logic [2:0] code_a, code_b;
    logic       valid_a, valid_b;
    logic       flush_a, flush_b;
    wire        InReady_a, InReady_b;
    wire        OutValid_a, OutValid_b;
    wire        Busy_a, Busy_b;
    wire  [7:0] out_a, out_b;

    int tests_run    = 0;
    int tests_failed = 0;

    decoder3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .In0(code_a[0]), .In1(code_a[1]), .In2(code_a[2]),
        .InValid(valid_a), .InReady(InReady_a), .Flush(flush_a),
        .Out0(out_a[0]), .Out1(out_a[1]), .Out2(out_a[2]), .Out3(out_a[3]),
        .Out4(out_a[4]), .Out5(out_a[5]), .Out6(out_a[6]), .Out7(out_a[7]),
        .OutValid(OutValid_a), .Busy(Busy_a)
    );

    decoder3to8_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n),
        .In0(code_b[0]), .In1(code_b[1]), .In2(code_b[2]),
        .InValid(valid_b), .InReady(InReady_b), .Flush(flush_b),
        .Out0(out_b[0]), .Out1(out_b[1]), .Out2(out_b[2]), .Out3(out_b[3]),
        .Out4(out_b[4]), .Out5(out_b[5]), .Out6(out_b[6]), .Out7(out_b[7]),
        .OutValid(OutValid_b), .Busy(Busy_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] oh(input int i);
        logic [7:0] one;
        one = 8'd1;
        return one << i;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the code.
    task automatic push_a(input int c, output int stalls);
        stalls  = 0;
        code_a  = 3'(c);
        valid_a = 1'b1;
        @(negedge Clk);
        while (!InReady_a && stalls < 60) begin
            stalls++;
            @(negedge Clk);
        end
        if (!InReady_a) begin
            tests_run++; tests_failed++;
            $display("FAIL push_timeout: code %0d never accepted, InReady=%b required 1", c, InReady_a);
        end
        @(posedge Clk); #1;
        valid_a = 1'b0;
    endtask

    task automatic wait_idle;
        int w;
        w = 0;
        @(negedge Clk);
        while ((Busy_a || Busy_b) && w < 200) begin
            w++;
            @(negedge Clk);
        end
        if (Busy_a || Busy_b) begin
            tests_run++; tests_failed++;
            $display("FAIL idle_timeout: Busy_a=%b Busy_b=%b required 0", Busy_a, Busy_b);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset;
        int st;
        #1;
        tests_run++;
        if ({out_a, OutValid_a, Busy_a, InReady_a} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_state: out=%h ov=%b busy=%b rdy=%b required all 0", out_a, OutValid_a, Busy_a, InReady_a);
        end
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        tests_run++;
        if (InReady_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_before_edge: InReady=%b required 0", InReady_a);
        end
        @(negedge Clk);
        tests_run++;
        if (InReady_a !== 1'b1 || Busy_a !== 1'b0 || InReady_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_release: rdy=%b busy=%b rdy_b=%b required 1 0 1", InReady_a, Busy_a, InReady_b);
        end
        @(posedge Clk); #1;
        push_a(2, st);
        @(negedge Clk);
        @(negedge Clk);
        tests_run++;
        if (out_a !== 8'h04 || OutValid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_pulse: out=%h ov=%b required 04 1", out_a, OutValid_a);
        end
        #2 Rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_a, OutValid_a, Busy_a, InReady_a} !== 11'd0) begin
            tests_failed++;
            $display("FAIL async_reset_drop: out=%h ov=%b busy=%b rdy=%b required all 0", out_a, OutValid_a, Busy_a, InReady_a);
        end
        @(posedge Clk); #1 Rst_n = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        tests_run++;
        if (InReady_a !== 1'b1 || Busy_a !== 1'b0 || out_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL post_reset: rdy=%b busy=%b out=%h required 1 0 00", InReady_a, Busy_a, out_a);
        end
        repeat (4) @(negedge Clk);
        tests_run++;
        if (out_a !== 8'h00 || Busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL buffered_lost: out=%h busy=%b required 00 0", out_a, Busy_a);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_single;
        int st;
        push_a(5, st);
        @(negedge Clk);
        tests_run++;
        if (out_a !== 8'h00 || Busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_latency: out=%h busy=%b required 00 1", out_a, Busy_a);
        end
        for (int h = 0; h < 4; h++) begin
            @(negedge Clk);
            tests_run++;
            if (out_a !== 8'h20 || OutValid_a !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_hold[%0d]: out=%h ov=%b required 20 1", h, out_a, OutValid_a);
            end
        end
        @(negedge Clk);
        tests_run++;
        if (out_a !== 8'h00 || OutValid_a !== 1'b0 || Busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_gap: out=%h ov=%b busy=%b required 00 0 1", out_a, OutValid_a, Busy_a);
        end
        @(negedge Clk);
        tests_run++;
        if (out_a !== 8'h00 || Busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: out=%h busy=%b required 00 0", out_a, Busy_a);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_all_codes;
        int st;
        int w;
        bit saw_full;
        saw_full = 1'b0;
        fork
            begin
                for (int c = 0; c < 8; c++) begin
                    push_a(c, st);
                    if (st > 0) saw_full = 1'b1;
                end
            end
            begin
                w = 0;
                @(negedge Clk);
                while (!OutValid_a && w < 40) begin
                    w++;
                    @(negedge Clk);
                end
                for (int i = 0; i < 8; i++) begin
                    for (int h = 0; h < 4; h++) begin
                        if (!(i == 0 && h == 0)) @(negedge Clk);
                        tests_run++;
                        if (out_a !== oh(i)) begin
                            tests_failed++;
                            $display("FAIL all_hold[%0d.%0d]: out=%h required %h", i, h, out_a, oh(i));
                        end
                    end
                    @(negedge Clk);
                    tests_run++;
                    if (out_a !== 8'h00) begin
                        tests_failed++;
                        $display("FAIL all_gap[%0d]: out=%h required 00", i, out_a);
                    end
                end
                @(negedge Clk);
                tests_run++;
                if (Busy_a !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL all_done: busy=%b required 0", Busy_a);
                end
            end
        join
        tests_run++;
        if (saw_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL all_ready_drop: saw_full=%b required 1", saw_full);
        end
        wait_idle();
    endtask

    task automatic test_full_boundary;
        int st;
        int w;
        int exp_seq [6];
        exp_seq = '{7, 1, 2, 3, 4, 5};
        fork
            begin
                push_a(7, st);
                for (int c = 1; c < 5; c++) push_a(c, st);
                tests_run++;
                if (st !== 0) begin
                    tests_failed++;
                    $display("FAIL full_fourth_stall: stalls=%0d required 0", st);
                end
                push_a(5, st);
                tests_run++;
                if (st !== 2) begin
                    tests_failed++;
                    $display("FAIL full_fifth_stall: stalls=%0d required 2", st);
                end
            end
            begin
                w = 0;
                @(negedge Clk);
                while (!OutValid_a && w < 40) begin
                    w++;
                    @(negedge Clk);
                end
                for (int i = 0; i < 6; i++) begin
                    for (int h = 0; h < 4; h++) begin
                        if (!(i == 0 && h == 0)) @(negedge Clk);
                        tests_run++;
                        if (out_a !== oh(exp_seq[i])) begin
                            tests_failed++;
                            $display("FAIL full_hold[%0d.%0d]: out=%h required %h", i, h, out_a, oh(exp_seq[i]));
                        end
                    end
                    @(negedge Clk);
                    tests_run++;
                    if (out_a !== 8'h00) begin
                        tests_failed++;
                        $display("FAIL full_gap[%0d]: out=%h required 00", i, out_a);
                    end
                end
                repeat (3) @(negedge Clk);
                tests_run++;
                if (out_a !== 8'h00 || Busy_a !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL full_no_dup: out=%h busy=%b required 00 0", out_a, Busy_a);
                end
            end
        join
        wait_idle();
    endtask

    task automatic test_gap0;
        code_b  = 3'd2;
        valid_b = 1'b1;
        @(negedge Clk);
        tests_run++;
        if (InReady_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap0_ready: rdy=%b required 1", InReady_b);
        end
        @(posedge Clk); #1 code_b = 3'd6;
        @(negedge Clk);
        tests_run++;
        if (out_b !== 8'h00 || Busy_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap0_latency: out=%h busy=%b required 00 1", out_b, Busy_b);
        end
        @(posedge Clk); #1 valid_b = 1'b0;
        @(negedge Clk);
        tests_run++;
        if (out_b !== 8'h04 || OutValid_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap0_first: out=%h ov=%b required 04 1", out_b, OutValid_b);
        end
        @(negedge Clk);
        tests_run++;
        if (out_b !== 8'h40 || OutValid_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap0_second: out=%h ov=%b required 40 1", out_b, OutValid_b);
        end
        @(negedge Clk);
        tests_run++;
        if (out_b !== 8'h00 || OutValid_b !== 1'b0 || Busy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap0_done: out=%h ov=%b busy=%b required 00 0 0", out_b, OutValid_b, Busy_b);
        end
        wait_idle();
    endtask

    task automatic test_flush;
        int st;
        push_a(3, st);
        for (int c = 4; c < 7; c++) push_a(c, st);
        flush_a = 1'b1;
        code_a  = 3'd1;
        valid_a = 1'b1;
        @(negedge Clk);
        tests_run++;
        if (out_a !== 8'h08 || Busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_pre: out=%h busy=%b required 08 1", out_a, Busy_a);
        end
        @(posedge Clk); #1;
        flush_a = 1'b0;
        valid_a = 1'b0;
        @(negedge Clk);
        tests_run++;
        if (out_a !== 8'h00 || OutValid_a !== 1'b0 || Busy_a !== 1'b0 || InReady_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_edge: out=%h ov=%b busy=%b rdy=%b required 00 0 0 1", out_a, OutValid_a, Busy_a, InReady_a);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            tests_run++;
            if (out_a !== 8'h00 || Busy_a !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_after[%0d]: out=%h busy=%b required 00 0", i, out_a, Busy_a);
            end
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        Rst_n   = 1'b0;
        code_a  = 3'd0;
        code_b  = 3'd0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        test_reset();
        test_single();
        test_all_codes();
        test_full_boundary();
        test_gap0();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d required completion", tests_run);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/decoder3to8_seq.md
# decoder3to8_seq

Sequenced 3-to-8 decoder, the receive-side counterpart of the 8-to-3 encoder. Accepts 3-bit codes through a valid/ready handshake and buffers them in a small FIFO. Replays each code as a one-hot pulse on Out0..Out7 held for a fixed number of cycles, separated by a fixed idle gap. It sits between a code producer (encoder output, CPU register, test sequencer) and eight one-hot select/strobe lines.

## Interface
- HOLD_CYCLES, 4: cycles each one-hot pattern stays asserted; legal 1..255.
- GAP_CYCLES, 1: all-zero cycles inserted after each pattern; legal 0..255.
- FIFO_DEPTH, 4: code buffer entries; power of two, 2..16.
- Clk  input  1  single clock, rising edge.
- Rst_n  input  1  reset, asynchronous assert, active-low.
- In0, In1, In2  input  1 each  code bits, In0 = LSB.
- InValid  input  1  code present on In0..In2.
- InReady  output  1  buffer can accept a code.
- Flush  input  1  synchronous abort: empty FIFO, drop active pulse.
- Out0..Out7  output  1 each  one-hot decoded lines, registered.
- OutValid  output  1  high whenever any Out line is high.
- Busy  output  1  FSM not IDLE or FIFO non-empty.

## Operation
- Reset (Rst_n low, async): FIFO empty, FSM IDLE, counters 0, Out0..Out7 = 0, OutValid = 0, Busy = 0, InReady = 0 while Rst_n low, 1 from first edge after release.
- Push: InValid && InReady at rising edge writes {In2,In1,In0} to FIFO. InReady = !full, registered-free (combinational from count); no pass-through when full, even if a pop occurs same cycle.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE: FIFO non-empty -> pop head, load Out with 1 << code, cnt = HOLD_CYCLES-1, go DRIVE.
  - DRIVE: cnt != 0 -> decrement. cnt == 0 -> clear Out; if GAP_CYCLES > 0 go GAP with cnt = GAP_CYCLES-1; else if FIFO non-empty pop next and stay DRIVE (back-to-back, no zero cycle); else IDLE.
  - GAP: cnt != 0 -> decrement; cnt == 0 -> same as IDLE decision (pop and DRIVE, else IDLE).
- Exactly one Out line high in DRIVE; all low otherwise.
- Flush (priority over everything except reset): next edge FIFO empty, FSM IDLE, Out = 0; a push coincident with Flush is discarded.
- Counters 8-bit; pointers log2(FIFO_DEPTH) bits with wrap; occupancy count log2(FIFO_DEPTH)+1 bits.

## Timing
- Latency: code accepted at edge k into empty FIFO with FSM IDLE -> Out line high after edge k+1.
- Pulse width exactly HOLD_CYCLES cycles; gap exactly GAP_CYCLES cycles; period per code HOLD_CYCLES+GAP_CYCLES.
- Push and pop in same cycle: occupancy unchanged, both take effect.
- Reset asserted mid-pulse: Out drops immediately (async), buffered codes lost.
- Busy falls the cycle Out returns to 0 with FIFO empty and FSM entering IDLE.

## Structure
- Shared package: FSM state encoding (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2), counter width constant CNT_W=8.
- One sub-module: code_fifo (parameterised synchronous FIFO, width 3, push/pop/full/empty/flush). FSM, counter and one-hot decode in top level.

## Test plan
- Reset: Rst_n low mid-pulse -> all Out 0 immediately, InReady 0; after release, InReady 1, Busy 0.
- Single code: push 3'b101 at defaults -> Out5 high 4 cycles starting edge k+1, then 1 zero cycle, Busy low after.
- All codes: push 0..7 back-to-back -> Out0..Out7 each high 4 cycles in order, one zero cycle between, InReady drops when 4 buffered.
- Full boundary: push 5 codes while FSM busy -> 5th held off (InReady 0) until first pop, accepted next cycle, no code lost or duplicated.
- GAP_CYCLES=0, HOLD_CYCLES=1: push 2,6 -> Out2 one cycle immediately followed by Out6 one cycle, OutValid continuous 2 cycles.
- Flush during DRIVE with 3 codes queued -> next edge Out 0, FIFO empty, Busy 0; coincident push discarded.
